proc_run_sequencer: RTL and testbench

- Synthesisable run controller for N_CH multicycle processor instances.
- Sequences each core's reset/start, watches every core's output bus, and captures the first non-zero output per channel.
- Compares captured values against expected values and reports done/pass/timeout.
- Sits between a top-level control source and the processor array; replaces bench-only "out > 0 then stop" checking with hardware that works on silicon and in simulation.

---
 rtl/proc_run_pkg.sv | 28 ++
 rtl/proc_run_capture.sv | 53 +++++
 rtl/proc_run_sequencer.sv | 168 ++++++++++++++++
 tb/tb_proc_run_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_run_pkg.sv
//------------------------------------------------------------------------------
// Module   : proc_run_pkg
// Desc     : Shared types and helpers for the processor run sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package proc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_DLY  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 16;

  // Low bit index of channel ch in a bus packed at w bits per channel.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_run_capture.sv
//------------------------------------------------------------------------------
// Module   : proc_run_capture
// Desc     : Per-channel first-non-zero capture with compare against expected.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_run_capture
  import proc_run_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_exp,
  output logic              o_hit,
  output logic              o_ok,
  output logic [DATA_W-1:0] o_value
);

  logic              r_hit;
  logic              r_ok;
  logic [DATA_W-1:0] r_value;
  logic              w_take;

  assign w_take = i_arm & ~r_hit & (i_data != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit   <= 1'b0;
      r_ok    <= 1'b0;
      r_value <= '0;
    end else if (i_clear) begin
      r_hit   <= 1'b0;
      r_ok    <= 1'b0;
      r_value <= '0;
    end else if (w_take) begin
      r_hit   <= 1'b1;
      r_ok    <= (i_data == i_exp);
      r_value <= i_data;
    end
  end

  assign o_hit   = r_hit;
  assign o_ok    = r_ok;
  assign o_value = r_value;

endmodule

`default_nettype wire

// File: rtl/proc_run_sequencer.sv
//------------------------------------------------------------------------------
// Module   : proc_run_sequencer
// Desc     : Run controller: sequences core reset/start, captures first non-zero
//            output per channel, reports done/pass/timeout.
//            Optional per-channel latency output: PROC_RUN_LATENCY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_run_sequencer
  import proc_run_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int N_CH      = 4,
  parameter int RST_CYC   = 2,
  parameter int START_DLY = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_go,
  input  logic [N_CH*DATA_W-1:0] i_dut_out,
  input  logic [N_CH*DATA_W-1:0] i_expected,
  output logic                   o_dut_rst,
  output logic                   o_dut_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic                   o_timeout,
  output logic [N_CH-1:0]        o_ch_hit,
  output logic [N_CH-1:0]        o_ch_ok,
  output logic [N_CH*DATA_W-1:0] o_result,
  output logic [CNT_W-1:0]       o_run_cycles
`ifdef PROC_RUN_LATENCY_EN
  ,
  output logic [N_CH*CNT_W-1:0]  o_ch_lat
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_ph_cnt;
  logic [CNT_W-1:0]       r_run_cycles;
  logic [N_CH*DATA_W-1:0] r_exp;
  logic                   r_pass;
  logic                   r_timeout;

  logic                   w_go_ok;
  logic                   w_arm;
  logic                   w_all_hit;
  logic                   w_tmo_hit;
  logic [N_CH-1:0]        w_hit;
  logic [N_CH-1:0]        w_ok;
  logic [N_CH-1:0]        w_take;
  logic [N_CH-1:0]        w_hit_now;
  logic [N_CH-1:0]        w_ok_now;

  assign w_go_ok   = i_go & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_arm     = (r_state == S_RUN);
  assign w_all_hit = &w_hit_now;
  assign w_tmo_hit = (r_run_cycles >= CNT_W'(TIMEOUT - 1));

  // Hit/ok as they will be after this edge, so exit and pass see same-cycle captures.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int LO = slice_lo(k, DATA_W);
    logic [DATA_W-1:0] w_slice;
    assign w_slice      = i_dut_out[LO +: DATA_W];
    assign w_take[k]    = w_arm & ~w_hit[k] & (w_slice != '0);
    assign w_hit_now[k] = w_hit[k] | (w_slice != '0);
    assign w_ok_now[k]  = w_hit[k] ? w_ok[k] : (w_slice == r_exp[LO +: DATA_W]);

    proc_run_capture #(
      .DATA_W (DATA_W)
    ) u_cap (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_go_ok),
      .i_arm   (w_arm),
      .i_data  (w_slice),
      .i_exp   (r_exp[LO +: DATA_W]),
      .o_hit   (w_hit[k]),
      .o_ok    (w_ok[k]),
      .o_value (o_result[LO +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_go) w_state_nxt = S_RST;
      S_RST: if (r_ph_cnt == CNT_W'(RST_CYC - 1))
               w_state_nxt = (START_DLY == 0) ? S_RUN : S_DLY;
      S_DLY: if (r_ph_cnt == CNT_W'(START_DLY - 1)) w_state_nxt = S_RUN;
      S_RUN: if (w_all_hit || w_tmo_hit) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_dut_rst   = (r_state == S_IDLE) | (r_state == S_RST);
    o_dut_start = (r_state == S_RUN);
    o_busy      = (r_state == S_RST) | (r_state == S_DLY) | (r_state == S_RUN);
    o_done      = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ph_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_ph_cnt <= '0;
    end else if ((r_state == S_RST) || (r_state == S_DLY)) begin
      r_ph_cnt <= r_ph_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_exp        <= '0;
      r_run_cycles <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (w_go_ok) begin
      r_exp        <= i_expected;
      r_run_cycles <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + 1'b1;
      if (w_state_nxt == S_DONE) begin
        r_pass    <= w_all_hit & (&w_ok_now);
        r_timeout <= ~w_all_hit;
      end
    end
  end

  assign o_pass       = r_pass;
  assign o_timeout    = r_timeout;
  assign o_ch_hit     = w_hit;
  assign o_ch_ok      = w_ok;
  assign o_run_cycles = r_run_cycles;

`ifdef PROC_RUN_LATENCY_EN
  logic [N_CH*CNT_W-1:0] r_ch_lat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ch_lat <= '0;
    end else if (w_go_ok) begin
      r_ch_lat <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_take[k]) r_ch_lat[k*CNT_W +: CNT_W] <= r_run_cycles;
      end
    end
  end

  assign o_ch_lat = r_ch_lat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_run_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_proc_run_sequencer
// Desc     : Scoreboard bench for proc_run_sequencer (TIMEOUT=16).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_proc_run_sequencer;

  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [3:0]  hit;
    logic [3:0]  ok;
    logic [31:0] result;
    logic [15:0] run;
    logic [63:0] lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        i_go;
  logic [31:0] i_dut_out;
  logic [31:0] i_expected;
  logic        o_dut_rst, o_dut_start, o_busy, o_done, o_pass, o_timeout;
  logic [3:0]  o_ch_hit, o_ch_ok;
  logic [31:0] o_result;
  logic [15:0] o_run_cycles;
`ifdef PROC_RUN_LATENCY_EN
  logic [63:0] o_ch_lat;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  proc_run_sequencer #(
    .DATA_W(DATA_W), .N_CH(N_CH), .RST_CYC(2), .START_DLY(2),
    .TIMEOUT(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .i_go(i_go), .i_dut_out(i_dut_out),
    .i_expected(i_expected), .o_dut_rst(o_dut_rst), .o_dut_start(o_dut_start),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_ch_hit(o_ch_hit), .o_ch_ok(o_ch_ok), .o_result(o_result),
    .o_run_cycles(o_run_cycles)
`ifdef PROC_RUN_LATENCY_EN
    , .o_ch_lat(o_ch_lat)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel outputs per scenario and RUN-cycle index (first RUN cycle = 0).
  function automatic logic [31:0] stim(input int sc, input int r);
    logic [31:0] v;
    v = '0;
    case (sc)
      0, 1, 2: begin
        if (r >= 3) v[7:0] = 8'h11;
        if (r >= 5) begin
          v[15:8]  = 8'h22;
          v[23:16] = (sc == 1 && r < 7) ? 8'h30 : 8'h33;
        end
        if (r >= 9 && sc != 2) v[31:24] = 8'h44;
      end
      3: begin
        if (r >= 1) v[7:0]   = 8'h0D;
        if (r >= 2) v[15:8]  = 8'h0C;
        if (r >= 4) v[31:16] = 16'h0A0B;
      end
      default: begin
        v[23:0] = 24'h020304;
        if (r >= 15) v[31:24] = 8'h01;
      end
    endcase
    return v;
  endfunction

  task automatic do_run(input int sc, input logic [31:0] expv, input exp_t e);
    logic got;
    i_expected = expv;
    i_go       = 1'b1;
    sb.push_back(e);
    tick();
    i_go = 1'b0;
    chk("rst_phase", {61'd0, o_dut_rst, o_busy, o_done}, 64'b110);
    tick();
    chk("rst_hold", o_dut_rst, 1);
    tick();
    chk("dly_phase", {o_dut_rst, o_dut_start}, 2'b00);
    tick();
    tick();
    chk("run_start", o_dut_start, 1);
    got = 1'b0;
    for (int r = 0; r < 40 && !got; r++) begin
      i_dut_out = stim(sc, r);
      if (sc == 3 && r == 2) begin
        i_go       = 1'b1;
        i_expected = '0;
      end
      tick();
      if (sc == 3 && r == 2) chk("go_ignored", {o_busy, o_dut_start}, 2'b11);
      i_go = 1'b0;
      got  = o_done;
    end
    chk("run_done", o_done, 1);
    i_dut_out = '0;
    tick();
    chk("done_hold", {o_done, o_dut_start, o_dut_rst}, 3'b100);
  endtask

  // Monitor: on each rising done, pop the expected record and compare.
  initial begin : g_monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_done && !prev) begin
        chk("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pass", o_pass, e.pass);
          chk("timeout", o_timeout, e.tmo);
          chk("ch_hit", o_ch_hit, e.hit);
          chk("ch_ok", o_ch_ok, e.ok);
          chk("result", o_result, e.result);
          chk("run_cycles", o_run_cycles, e.run);
`ifdef PROC_RUN_LATENCY_EN
          chk("ch_lat", o_ch_lat, e.lat);
`endif
        end
      end
      prev = o_done;
    end
  end

  initial begin : g_watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : g_stim
    reset      = 1'b0;
    i_go       = 1'b0;
    i_dut_out  = '0;
    i_expected = '0;
    repeat (3) tick();
    chk("rst_dut_rst", o_dut_rst, 1);
    chk("rst_flags", {o_dut_start, o_busy, o_done, o_pass, o_timeout}, 5'b0);
    chk("rst_result", o_result, 0);
    chk("rst_hit_ok_cyc", {o_ch_hit, o_ch_ok, o_run_cycles}, 0);
    reset = 1'b1;
    tick();

    // Nominal: captures at RUN cycles 3,5,5,9 -> done after cycle 9.
    do_run(0, 32'h44332211, '{1'b1, 1'b0, 4'hF, 4'hF, 32'h44332211, 16'd10,
                              {16'd9, 16'd5, 16'd5, 16'd3}});
    // Mismatch on ch2 (0x30), later 0x33 is ignored; also a go from DONE.
    do_run(1, 32'h44332211, '{1'b0, 1'b0, 4'hF, 4'b1011, 32'h44302211, 16'd10,
                              {16'd9, 16'd5, 16'd5, 16'd3}});
    // ch3 never produces: timeout after 16 RUN cycles.
    do_run(2, 32'h44332211, '{1'b0, 1'b1, 4'b0111, 4'b0111, 32'h00332211, 16'd16,
                              {16'd0, 16'd5, 16'd5, 16'd3}});
    // Last hit lands on the timeout cycle: all-hit wins.
    do_run(4, 32'h01020304, '{1'b1, 1'b0, 4'hF, 4'hF, 32'h01020304, 16'd16,
                              {16'd15, 16'd0, 16'd0, 16'd0}});

    // Reset mid-RUN after some captures have occurred.
    i_expected = 32'h44332211;
    i_go       = 1'b1;
    tick();
    i_go = 1'b0;
    repeat (4) tick();
    for (int r = 0; r < 6; r++) begin
      i_dut_out = stim(0, r);
      tick();
    end
    chk("pre_reset_hit", o_ch_hit, 4'b0111);
    reset = 1'b0;
    tick();
    chk("midrst_flags", {o_dut_rst, o_dut_start, o_busy, o_done}, 4'b1000);
    chk("midrst_result", o_result, 0);
    chk("midrst_hit_cyc", {o_ch_hit, o_ch_ok, o_run_cycles}, 0);
    reset     = 1'b1;
    i_dut_out = '0;
    tick();

    // Run from IDLE with a go pulse (and changed expected) injected mid-RUN.
    do_run(3, 32'h0A0B0C0D, '{1'b1, 1'b0, 4'hF, 4'hF, 32'h0A0B0C0D, 16'd5,
                              {16'd4, 16'd4, 16'd2, 16'd1}});

    tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
